alu_issue: RTL and testbench

- Operand-issue and write-back stage that sits directly around the 32-bit combinational ALU.
- Accepts one register-to-register or register-immediate command through a valid/ready handshake.
- Reads operands from an internal 8x32 register file, drives the ALU's A/B/ALUOp inputs, and captures the ALU's C output.
- Writes the result back to the register file and reports it on a write-back strobe.

---
 rtl/alu_issue_if.sv | 41 ++++
 rtl/alu_issue.sv | 141 ++++++++++++++
 tb/tb_alu_issue.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_if.sv
// alu_issue_if: bundle of the command handshake, the ALU operand/result
// lines and the write-back report for the alu_issue block.
//   slave  - the alu_issue block (consumes commands, drives the ALU, reports)
//   master - the environment (command producer plus the combinational ALU)
// Handshake: a command transfers on a rising clk edge where cmd_valid and
// cmd_ready are both high; the producer holds every cmd_* field stable from
// raising cmd_valid until that edge, and the block never buffers a command.
interface alu_issue_if #(
  parameter int W = 32
);
  logic         cmd_valid;
  logic         cmd_ready;
  logic [2:0]   cmd_op;
  logic [2:0]   cmd_rd;
  logic [2:0]   cmd_rs;
  logic [2:0]   cmd_rt;
  logic         cmd_imm_en;
  logic [15:0]  cmd_imm;
  logic [W-1:0] alu_A;
  logic [W-1:0] alu_B;
  logic [2:0]   alu_op;
  logic [W-1:0] alu_C;
  logic         wb_valid;
  logic [2:0]   wb_rd;
  logic [W-1:0] wb_data;
  logic         err;

  modport slave (
    input  cmd_valid, cmd_op, cmd_rd, cmd_rs, cmd_rt, cmd_imm_en, cmd_imm,
    input  alu_C,
    output cmd_ready, alu_A, alu_B, alu_op,
    output wb_valid, wb_rd, wb_data, err
  );

  modport master (
    output cmd_valid, cmd_op, cmd_rd, cmd_rs, cmd_rt, cmd_imm_en, cmd_imm,
    output alu_C,
    input  cmd_ready, alu_A, alu_B, alu_op,
    input  wb_valid, wb_rd, wb_data, err
  );
endinterface

// File: rtl/alu_issue.sv
// alu_issue: operand-issue and write-back stage around a combinational ALU.
// Accepts one command, reads operands from an internal register file
// (register 0 hardwired to zero), presents them to the ALU, captures the
// result and writes it back. One command every 3 cycles: IDLE -> EXEC -> WB.
// Ports:
//   clk, reset  - rising-edge clock, asynchronous active-high reset
//   bus         - alu_issue_if.slave (command, ALU lines, write-back report)
//   dbg_addr    - debug register index
//   dbg_data    - combinational read of reg[dbg_addr] (0 for index 0)
//   dbg_state   - current FSM state (0 IDLE, 1 EXEC, 2 WB)
module alu_issue #(
  parameter int NREG = 8,
  parameter int W    = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  alu_issue_if.slave              bus,
  input  logic [$clog2(NREG)-1:0] dbg_addr,
  output logic [W-1:0]            dbg_data,
  output logic [1:0]              dbg_state
);
  localparam int AW = $clog2(NREG);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [W-1:0]  regs_q [NREG];
  logic [W-1:0]  regs_d [NREG];
  logic [W-1:0]  alu_a_q, alu_a_d;
  logic [W-1:0]  alu_b_q, alu_b_d;
  logic [2:0]    alu_op_q, alu_op_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [W-1:0]  result_q, result_d;
  logic          wb_valid_q, wb_valid_d;
  logic [AW-1:0] wb_rd_q, wb_rd_d;
  logic [W-1:0]  wb_data_q, wb_data_d;
  logic          err_q, err_d;

  logic [W-1:0]  imm_ext;
  logic [W-1:0]  rs_val;
  logic [W-1:0]  rt_val;
  logic          op_legal;

  // add/sub take a signed immediate; logic ops and shifts take it unsigned
  always_comb begin
    if (bus.cmd_op == 3'b000 || bus.cmd_op == 3'b001)
      imm_ext = {{(W-16){bus.cmd_imm[15]}}, bus.cmd_imm};
    else
      imm_ext = {{(W-16){1'b0}}, bus.cmd_imm};
  end

  assign rs_val   = (bus.cmd_rs == '0) ? '0 : regs_q[bus.cmd_rs];
  assign rt_val   = (bus.cmd_rt == '0) ? '0 : regs_q[bus.cmd_rt];
  assign op_legal = (alu_op_q <= 3'b101);

  always_comb begin
    state_d    = state_q;
    regs_d     = regs_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_op_d   = alu_op_q;
    rd_d       = rd_q;
    result_d   = result_q;
    wb_valid_d = 1'b0;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    err_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          alu_a_d  = rs_val;
          alu_b_d  = bus.cmd_imm_en ? imm_ext : rt_val;
          alu_op_d = bus.cmd_op;
          rd_d     = bus.cmd_rd;
          state_d  = EXEC;
        end
      end
      EXEC: begin
        result_d = bus.alu_C;
        state_d  = WB;
      end
      WB: begin
        // rd = 0 still reports the result, but the write is discarded
        if (op_legal) begin
          wb_valid_d = 1'b1;
          wb_rd_d    = rd_q;
          wb_data_d  = result_q;
          if (rd_q != '0) regs_d[rd_q] = result_q;
        end else begin
          err_d = 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_op_q   <= 3'b000;
      rd_q       <= '0;
      result_q   <= '0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      for (int i = 0; i < NREG; i++) regs_q[i] <= regs_d[i];
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_op_q   <= alu_op_d;
      rd_q       <= rd_d;
      result_q   <= result_d;
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      err_q      <= err_d;
    end
  end

  assign bus.cmd_ready = (state_q == IDLE);
  assign bus.alu_A     = alu_a_q;
  assign bus.alu_B     = alu_b_q;
  assign bus.alu_op    = alu_op_q;
  assign bus.wb_valid  = wb_valid_q;
  assign bus.wb_rd     = wb_rd_q;
  assign bus.wb_data   = wb_data_q;
  assign bus.err       = err_q;

  assign dbg_data  = (dbg_addr == '0) ? '0 : regs_q[dbg_addr];
  assign dbg_state = state_q;
endmodule

// File: tb/tb_alu_issue.sv
module tb_alu_issue;
  logic        clk;
  logic        reset;
  logic [2:0]  dbg_addr;
  logic [31:0] dbg_data;
  logic [1:0]  dbg_state;

  alu_issue_if #(.W(32)) bus ();

  alu_issue #(.NREG(8), .W(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_addr  (dbg_addr),
    .dbg_data  (dbg_data),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end

  // reference ALU
  always_comb begin
    case (bus.alu_op)
      3'b000:  bus.alu_C = bus.alu_A + bus.alu_B;
      3'b001:  bus.alu_C = bus.alu_A - bus.alu_B;
      3'b010:  bus.alu_C = bus.alu_A & bus.alu_B;
      3'b011:  bus.alu_C = bus.alu_A | bus.alu_B;
      3'b100:  bus.alu_C = bus.alu_A >> bus.alu_B;
      3'b101:  bus.alu_C = $unsigned($signed(bus.alu_A) >>> bus.alu_B);
      default: bus.alu_C = 32'h0;
    endcase
  end

  typedef struct {
    logic [2:0]  op;
    logic [2:0]  rd;
    logic [2:0]  rs;
    logic [2:0]  rt;
    logic        imm_en;
    logic [15:0] imm;
    logic        exp_err;
    logic [31:0] exp_data;
    logic [2:0]  chk_reg;
    logic [31:0] chk_val;
  } vec_t;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [34:0] exp_q[$];
  logic [31:0] last_data;
  logic [2:0]  last_rd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // scoreboard: every wb_valid pulse must match the oldest expected result
  always @(negedge clk) begin
    if (!reset && bus.wb_valid) begin
      if (exp_q.size() == 0) begin
        chk("mon_unexpected_wb", 32'd1, 32'd0);
      end else begin
        logic [34:0] e;
        e = exp_q.pop_front();
        chk("mon_wb_data", bus.wb_data, e[31:0]);
        chk("mon_wb_rd", {29'd0, bus.wb_rd}, {29'd0, e[34:32]});
      end
    end
  end

  // driver tasks (called at a negedge)
  task automatic load_cmd(input vec_t v);
    bus.cmd_op     = v.op;
    bus.cmd_rd     = v.rd;
    bus.cmd_rs     = v.rs;
    bus.cmd_rt     = v.rt;
    bus.cmd_imm_en = v.imm_en;
    bus.cmd_imm    = v.imm;
  endtask

  task automatic run_vec(input vec_t v);
    int n;
    load_cmd(v);
    bus.cmd_valid = 1'b1;
    n = 0;
    while (!bus.cmd_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (!bus.cmd_ready) begin
      chk("accept_timeout", 32'd0, 32'd1);
      bus.cmd_valid = 1'b0;
      return;
    end
    if (!v.exp_err) exp_q.push_back({v.rd, v.exp_data});
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    chk("exec_ready", {31'd0, bus.cmd_ready}, 32'd0);
    chk("exec_state", {30'd0, dbg_state}, 32'd1);
    chk("exec_alu_op", {29'd0, bus.alu_op}, {29'd0, v.op});
    chk("exec_wb_valid", {31'd0, bus.wb_valid}, 32'd0);
    @(negedge clk);
    chk("wbst_wb_valid", {31'd0, bus.wb_valid}, 32'd0);
    chk("wbst_err", {31'd0, bus.err}, 32'd0);
    @(negedge clk);
    chk("res_wb_valid", {31'd0, bus.wb_valid}, {31'd0, !v.exp_err});
    chk("res_err", {31'd0, bus.err}, {31'd0, v.exp_err});
    chk("res_ready", {31'd0, bus.cmd_ready}, 32'd1);
    if (!v.exp_err) begin
      last_data = v.exp_data;
      last_rd   = v.rd;
    end
    chk("res_wb_data", bus.wb_data, last_data);
    chk("res_wb_rd", {29'd0, bus.wb_rd}, {29'd0, last_rd});
    dbg_addr = v.chk_reg;
    #1;
    chk("res_dbg_reg", dbg_data, v.chk_val);
  endtask

  vec_t vecs[15];
  vec_t strm[3];

  initial begin
    vecs[0]  = '{3'd0, 3'd1, 3'd0, 3'd0, 1'b1, 16'h7FFF, 1'b0, 32'h00007FFF, 3'd1, 32'h00007FFF};
    vecs[1]  = '{3'd1, 3'd2, 3'd1, 3'd0, 1'b1, 16'hFFFF, 1'b0, 32'h00008000, 3'd2, 32'h00008000};
    vecs[2]  = '{3'd5, 3'd3, 3'd2, 3'd0, 1'b1, 16'h0004, 1'b0, 32'h00000800, 3'd3, 32'h00000800};
    vecs[3]  = '{3'd0, 3'd4, 3'd0, 3'd0, 1'b1, 16'h8000, 1'b0, 32'hFFFF8000, 3'd4, 32'hFFFF8000};
    vecs[4]  = '{3'd5, 3'd5, 3'd4, 3'd0, 1'b1, 16'h0004, 1'b0, 32'hFFFFF800, 3'd5, 32'hFFFFF800};
    vecs[5]  = '{3'd4, 3'd6, 3'd4, 3'd0, 1'b1, 16'h0004, 1'b0, 32'h0FFFF800, 3'd6, 32'h0FFFF800};
    vecs[6]  = '{3'd3, 3'd0, 3'd1, 3'd2, 1'b0, 16'h0000, 1'b0, 32'h0000FFFF, 3'd0, 32'h00000000};
    vecs[7]  = '{3'd6, 3'd7, 3'd1, 3'd2, 1'b0, 16'h0000, 1'b1, 32'h00000000, 3'd7, 32'h00000000};
    vecs[8]  = '{3'd2, 3'd7, 3'd5, 3'd6, 1'b0, 16'h0000, 1'b0, 32'h0FFFF800, 3'd7, 32'h0FFFF800};
    vecs[9]  = '{3'd1, 3'd7, 3'd0, 3'd1, 1'b0, 16'h0000, 1'b0, 32'hFFFF8001, 3'd7, 32'hFFFF8001};
    vecs[10] = '{3'd2, 3'd3, 3'd4, 3'd0, 1'b1, 16'hF0F0, 1'b0, 32'h00008000, 3'd3, 32'h00008000};
    vecs[11] = '{3'd5, 3'd3, 3'd4, 3'd0, 1'b1, 16'h0040, 1'b0, 32'hFFFFFFFF, 3'd3, 32'hFFFFFFFF};
    vecs[12] = '{3'd4, 3'd3, 3'd4, 3'd0, 1'b1, 16'h0040, 1'b0, 32'h00000000, 3'd3, 32'h00000000};
    vecs[13] = '{3'd0, 3'd7, 3'd4, 3'd4, 1'b0, 16'h0000, 1'b0, 32'hFFFF0000, 3'd7, 32'hFFFF0000};
    vecs[14] = '{3'd7, 3'd1, 3'd2, 3'd3, 1'b0, 16'h0000, 1'b1, 32'h00000000, 3'd1, 32'h00007FFF};

    strm[0]  = '{3'd0, 3'd1, 3'd1, 3'd0, 1'b1, 16'h0001, 1'b0, 32'h00008000, 3'd0, 32'h0};
    strm[1]  = '{3'd0, 3'd1, 3'd1, 3'd0, 1'b1, 16'h0001, 1'b0, 32'h00008001, 3'd0, 32'h0};
    strm[2]  = '{3'd0, 3'd2, 3'd1, 3'd1, 1'b0, 16'h0000, 1'b0, 32'h00010002, 3'd0, 32'h0};

    reset         = 1'b1;
    bus.cmd_valid = 1'b0;
    load_cmd(vecs[0]);
    dbg_addr      = 3'd0;
    last_data     = 32'h0;
    last_rd       = 3'd0;

    // reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_wb_valid", {31'd0, bus.wb_valid}, 32'd0);
    chk("rst_err", {31'd0, bus.err}, 32'd0);
    chk("rst_alu_op", {29'd0, bus.alu_op}, 32'd0);
    reset = 1'b0;
    #1;
    chk("rst_ready", {31'd0, bus.cmd_ready}, 32'd1);
    chk("rst_state", {30'd0, dbg_state}, 32'd0);
    chk("rst_alu_A", bus.alu_A, 32'd0);
    chk("rst_alu_B", bus.alu_B, 32'd0);
    chk("rst_wb_data", bus.wb_data, 32'd0);
    chk("rst_wb_rd", {29'd0, bus.wb_rd}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 3'(i);
      #1;
      chk("rst_dbg_reg", dbg_data, 32'd0);
    end
    @(negedge clk);

    // table of back-to-back commands (each issued in the IDLE cycle after WB)
    for (int i = 0; i < 15; i++) run_vec(vecs[i]);

    // continuous cmd_valid over three dependent commands
    @(negedge clk);
    begin
      int acc;
      int n_ready;
      int n_wb;
      int acc_cyc[$];
      int wb_cyc[$];
      logic acc_now;
      acc = 0;
      n_ready = 0;
      n_wb = 0;
      load_cmd(strm[0]);
      bus.cmd_valid = 1'b1;
      for (int c = 0; c < 14; c++) begin
        acc_now = bus.cmd_valid && bus.cmd_ready;
        if (bus.cmd_ready && c < 9) n_ready++;
        if (acc_now) begin
          acc_cyc.push_back(c);
          exp_q.push_back({strm[acc].rd, strm[acc].exp_data});
        end
        if (bus.wb_valid) begin
          wb_cyc.push_back(c);
          n_wb++;
        end
        @(negedge clk);
        if (acc_now) begin
          acc++;
          if (acc < 3) load_cmd(strm[acc]);
          else bus.cmd_valid = 1'b0;
        end
      end
      bus.cmd_valid = 1'b0;
      chk("strm_ready_cycles", n_ready, 32'd3);
      chk("strm_accepts", acc_cyc.size(), 32'd3);
      chk("strm_wb_count", n_wb, 32'd3);
      if (acc_cyc.size() == 3 && wb_cyc.size() == 3) begin
        for (int k = 0; k < 3; k++) begin
          chk("strm_accept_cyc", acc_cyc[k], 32'(3 * k));
          chk("strm_wb_cyc", wb_cyc[k], 32'(3 * k + 3));
        end
      end
      last_data = 32'h00010002;
      last_rd   = 3'd2;
      dbg_addr = 3'd1;
      #1;
      chk("strm_dbg_r1", dbg_data, 32'h00008001);
      dbg_addr = 3'd2;
      #1;
      chk("strm_dbg_r2", dbg_data, 32'h00010002);
    end

    // reset during EXEC aborts the in-flight add to r7
    @(negedge clk);
    bus.cmd_op     = 3'd0;
    bus.cmd_rd     = 3'd7;
    bus.cmd_rs     = 3'd1;
    bus.cmd_imm_en = 1'b1;
    bus.cmd_imm    = 16'h0005;
    bus.cmd_valid  = 1'b1;
    chk("abort_ready", {31'd0, bus.cmd_ready}, 32'd1);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    chk("abort_in_exec", {30'd0, dbg_state}, 32'd1);
    reset = 1'b1;
    #1;
    chk("abort_state", {30'd0, dbg_state}, 32'd0);
    dbg_addr = 3'd1;
    #1;
    chk("abort_r1_cleared", dbg_data, 32'd0);
    @(negedge clk);
    chk("abort_wb_valid", {31'd0, bus.wb_valid}, 32'd0);
    reset = 1'b0;
    last_data = 32'h0;
    last_rd   = 3'd0;
    #1;
    chk("abort_ready_after", {31'd0, bus.cmd_ready}, 32'd1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("abort_no_wb", {31'd0, bus.wb_valid}, 32'd0);
      chk("abort_no_err", {31'd0, bus.err}, 32'd0);
    end
    dbg_addr = 3'd7;
    #1;
    chk("abort_r7", dbg_data, 32'd0);
    @(negedge clk);
    begin
      vec_t v;
      v = '{3'd0, 3'd7, 3'd0, 3'd0, 1'b1, 16'h1234, 1'b0, 32'h00001234, 3'd7, 32'h00001234};
      run_vec(v);
    end

    @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
